// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the umbral FIFO and its controlling FSM
package fifo_pkg;

  // Default geometry of one queue
  localparam int FIFO_DATA_WIDTH = 6;
  localparam int FIFO_ADDR_WIDTH = 3;
  localparam int FIFO_DEPTH      = 1 << FIFO_ADDR_WIDTH;
  localparam int FIFO_CNT_WIDTH  = FIFO_ADDR_WIDTH + 1;

  // Umbral widths of each queue class; the FSM drives thresholds of these widths
  localparam int MF_SIZE = FIFO_ADDR_WIDTH;
  localparam int VC_SIZE = FIFO_ADDR_WIDTH;
  localparam int D_SIZE  = FIFO_ADDR_WIDTH;

  // Identifies which queue an instance serves
  typedef enum logic [2:0] {
    Q_MF  = 3'd0,
    Q_VC0 = 3'd1,
    Q_VC1 = 3'd2,
    Q_D0  = 3'd3,
    Q_D1  = 3'd4
  } queue_id_e;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_WIDTH storage, one write port and one registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Array write; contents survive reset, stale words are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Read register samples the old word, so a same-address write lands after the read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_umbral.sv
// rtl/fifo_umbral.sv - synchronous FIFO with almost-empty/almost-full umbrals; FIFO_PEAK_EN adds peak occupancy
module fifo_umbral
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [ADDR_WIDTH-1:0] empty_umbral_in,
  input  logic [ADDR_WIDTH-1:0] full_umbral_in,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   max_count
);

  localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty;
  logic                  r_full;
  logic                  r_valid;
  logic                  r_err;

  logic                  w_push_ok;
  logic                  w_pop_ok;
  logic                  w_overflow;
  logic                  w_underflow;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // A push into a full queue is still taken when a pop frees the head slot on the same edge
  assign w_push_ok   = push & (~r_full | pop);
  assign w_pop_ok    = pop & ~r_empty;
  assign w_overflow  = push & r_full & ~pop;
  assign w_underflow = pop & r_empty;

  // Occupancy after this edge
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy, registered empty/full, read-valid and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == CNT_ZERO);
      r_full  <= (w_count_nxt == CNT_FULL);
      r_valid <= w_pop_ok;
      r_err   <= r_err | w_overflow | w_underflow;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_push_ok),
    .wr_addr (r_wr_ptr),
    .wr_data (data_in),
    .rd_en   (w_pop_ok),
    .rd_addr (r_rd_ptr),
    .rd_data (w_rd_data)
  );

`ifdef FIFO_PEAK_EN
  logic [ADDR_WIDTH:0] r_max_count;

  // Highest occupancy seen since reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_max_count <= '0;
    end else if (w_count_nxt > r_max_count) begin
      r_max_count <= w_count_nxt;
    end
  end

  assign max_count = r_max_count;
`else
  assign max_count = '0;
`endif

  // Umbral compares use live thresholds so an FSM update shows up in the same cycle
  assign almost_empty = (r_count <= {1'b0, empty_umbral_in});
  assign almost_full  = (r_count >= {1'b0, full_umbral_in});

  assign data_out   = w_rd_data;
  assign valid_out  = r_valid;
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;
  assign err        = r_err;
  assign count      = r_count;

endmodule

// File: tb/tb_fifo_umbral.sv
// tb/tb_fifo_umbral.sv - directed table-driven bench for fifo_umbral
module tb_fifo_umbral;

  logic       clk;
  logic       reset;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic [2:0] empty_umbral_in;
  logic [2:0] full_umbral_in;
  logic       fifo_empty;
  logic       fifo_full;
  logic       almost_empty;
  logic       almost_full;
  logic       err;
  logic [3:0] count;
  logic [3:0] max_count;

  int n_chk;
  int n_fail;

  fifo_umbral dut (
    .clk             (clk),
    .reset           (reset),
    .push            (push),
    .data_in         (data_in),
    .pop             (pop),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .empty_umbral_in (empty_umbral_in),
    .full_umbral_in  (full_umbral_in),
    .fifo_empty      (fifo_empty),
    .fifo_full       (fifo_full),
    .almost_empty    (almost_empty),
    .almost_full     (almost_full),
    .err             (err),
    .count           (count),
    .max_count       (max_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic       pop;
    logic [5:0] din;
    logic [2:0] eu;
    logic [2:0] fu;
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       ae;
    logic       af;
    logic       er;
    logic       vld;
    logic       chk_d;
    logic [5:0] dout;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic pu, logic po, logic [5:0] d, logic [2:0] eu, logic [2:0] fu,
                             logic [3:0] c, logic e, logic f, logic ae, logic af, logic er,
                             logic vl, logic cd, logic [5:0] dout);
    vec_t r;
    r.push = pu; r.pop = po; r.din = d; r.eu = eu; r.fu = fu;
    r.cnt = c; r.emp = e; r.ful = f; r.ae = ae; r.af = af; r.er = er;
    r.vld = vl; r.chk_d = cd; r.dout = dout;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    push = 1'b0; pop = 1'b0; data_in = 6'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] c;
    logic [5:0] exp_d;
    n_chk = 0;
    n_fail = 0;

    // Test 2: fill to 5 with eu=2 fu=5
    for (int k = 1; k <= 5; k++) begin
      c = 4'(k);
      vecs.push_back(v(1, 0, 6'(k), 3'd2, 3'd5, c, 0, 0, (k <= 2), (k >= 5), 0, 0, 0, 6'h00));
    end
    // Test 3: fill to 8, overflow, drain
    for (int k = 6; k <= 8; k++) begin
      c = 4'(k);
      vecs.push_back(v(1, 0, 6'(k), 3'd2, 3'd5, c, 0, (k == 8), 0, 1, 0, 0, 0, 6'h00));
    end
    vecs.push_back(v(1, 0, 6'h3F, 3'd2, 3'd5, 4'd8, 0, 1, 0, 1, 1, 0, 0, 6'h00));
    for (int k = 1; k <= 8; k++) begin
      c = 4'(8 - k);
      vecs.push_back(v(0, 1, 6'h00, 3'd2, 3'd5, c, (k == 8), 0, (8 - k <= 2), (8 - k >= 5), 1, 1, 1, 6'(k)));
    end
    vecs.push_back(v(0, 0, 6'h00, 3'd2, 3'd5, 4'd0, 1, 0, 1, 0, 1, 0, 1, 6'h08));
    // Zero umbrals: fu=0 forces almost_full even when empty
    vecs.push_back(v(0, 0, 6'h00, 3'd0, 3'd0, 4'd0, 1, 0, 1, 1, 1, 0, 1, 6'h08));
    // Test 4: underflow, then push+pop on empty
    vecs.push_back(v(0, 1, 6'h00, 3'd2, 3'd5, 4'd0, 1, 0, 1, 0, 1, 0, 1, 6'h08));
    vecs.push_back(v(1, 1, 6'h11, 3'd2, 3'd5, 4'd1, 0, 0, 1, 0, 1, 0, 1, 6'h08));
    vecs.push_back(v(0, 1, 6'h00, 3'd2, 3'd5, 4'd0, 1, 0, 1, 0, 1, 1, 1, 6'h11));
    // Test 5: fill, simultaneous push/pop while full, drain through wrap
    for (int k = 1; k <= 8; k++) begin
      c = 4'(k);
      vecs.push_back(v(1, 0, 6'(k), 3'd2, 3'd5, c, 0, (k == 8), (k <= 2), (k >= 5), 1, 0, 1, 6'h11));
    end
    vecs.push_back(v(0, 0, 6'h00, 3'd7, 3'd7, 4'd8, 0, 1, 0, 1, 1, 0, 1, 6'h11));
    vecs.push_back(v(1, 1, 6'h2A, 3'd2, 3'd5, 4'd8, 0, 1, 0, 1, 1, 1, 1, 6'h01));
    for (int k = 1; k <= 8; k++) begin
      c = 4'(8 - k);
      exp_d = (k < 8) ? 6'(k + 1) : 6'h2A;
      vecs.push_back(v(0, 1, 6'h00, 3'd2, 3'd5, c, (k == 8), 0, (8 - k <= 2), (8 - k >= 5), 1, 1, 1, exp_d));
    end
    vecs.push_back(v(0, 0, 6'h00, 3'd2, 3'd5, 4'd0, 1, 0, 1, 0, 1, 0, 1, 6'h2A));

    // Test 1: reset for two cycles
    reset = 1'b0;
    idle_inputs();
    empty_umbral_in = 3'd2;
    full_umbral_in  = 3'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.empty", 32'(fifo_empty), 32'd1);
    chk("rst.full", 32'(fifo_full), 32'd0);
    chk("rst.ae", 32'(almost_empty), 32'd1);
    chk("rst.af", 32'(almost_full), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.valid", 32'(valid_out), 32'd0);
    chk("rst.dout", 32'(data_out), 32'd0);
    chk("rst.max", 32'(max_count), 32'd0);

    // Table vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      push = vecs[i].push;
      pop = vecs[i].pop;
      data_in = vecs[i].din;
      empty_umbral_in = vecs[i].eu;
      full_umbral_in = vecs[i].fu;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d.empty", i), 32'(fifo_empty), 32'(vecs[i].emp));
      chk($sformatf("v%0d.full", i), 32'(fifo_full), 32'(vecs[i].ful));
      chk($sformatf("v%0d.ae", i), 32'(almost_empty), 32'(vecs[i].ae));
      chk($sformatf("v%0d.af", i), 32'(almost_full), 32'(vecs[i].af));
      chk($sformatf("v%0d.err", i), 32'(err), 32'(vecs[i].er));
      chk($sformatf("v%0d.valid", i), 32'(valid_out), 32'(vecs[i].vld));
      if (vecs[i].chk_d) begin
        chk($sformatf("v%0d.dout", i), 32'(data_out), 32'(vecs[i].dout));
      end
    end

    // Test 6: clean reset, underflow sets err, push 4, async reset mid-stream
    @(negedge clk);
    idle_inputs();
    empty_umbral_in = 3'd2;
    full_umbral_in  = 3'd0;
    reset = 1'b0;
    #1;
    chk("r6.af_fu0", 32'(almost_full), 32'd1);
    full_umbral_in = 3'd5;
    @(negedge clk);
    reset = 1'b1;
    pop = 1'b1;
    @(posedge clk);
    #1;
    chk("r6.uf_err", 32'(err), 32'd1);
    chk("r6.uf_valid", 32'(valid_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pop = 1'b0;
      push = 1'b1;
      data_in = 6'(6'h31 + k);
    end
    @(posedge clk);
    #1;
    chk("r6.count4", 32'(count), 32'd4);
`ifdef FIFO_PEAK_EN
    chk("r6.max4", 32'(max_count), 32'd4);
`else
    chk("r6.max4", 32'(max_count), 32'd0);
`endif
    @(negedge clk);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    chk("r6.async_count", 32'(count), 32'd0);
    chk("r6.async_err", 32'(err), 32'd0);
    chk("r6.async_empty", 32'(fifo_empty), 32'd1);
    chk("r6.async_valid", 32'(valid_out), 32'd0);
    chk("r6.async_dout", 32'(data_out), 32'd0);
    chk("r6.async_max", 32'(max_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("r6.post_count", 32'(count), 32'd0);
    chk("r6.post_empty", 32'(fifo_empty), 32'd1);
    chk("r6.post_ae", 32'(almost_empty), 32'd1);

    // Stale memory must not reappear: the first word after reset is the new one
    @(negedge clk);
    push = 1'b1;
    data_in = 6'h15;
    @(negedge clk);
    push = 1'b0;
    pop = 1'b1;
    @(posedge clk);
    #1;
    chk("r6.fresh_dout", 32'(data_out), 32'h15);
    chk("r6.fresh_valid", 32'(valid_out), 32'd1);
    @(negedge clk);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_umbral.md
Name: fifo_umbral

Overview:
Synchronous FIFO with programmable almost-empty and almost-full thresholds ("umbrals").
- Used for the MF, VC0/VC1 and D0/D1 queues.
- Sits directly downstream of the control FSM: consumes its empty/full umbral outputs.
- Feeds the FSM's empty_sig and err_sig inputs.

Parameters:
DATA_WIDTH, 6, width of each stored word
ADDR_WIDTH, 3, log2 of depth (DEPTH = 8); also the width of the umbral inputs

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
push  input  1  write request
data_in  input  DATA_WIDTH  write data
pop  input  1  read request
data_out  output  DATA_WIDTH  read data, registered
valid_out  output  1  data_out holds a word popped on the previous edge
empty_umbral_in  input  ADDR_WIDTH  almost-empty threshold from FSM
full_umbral_in  input  ADDR_WIDTH  almost-full threshold from FSM
fifo_empty  output  1  occupancy == 0
fifo_full  output  1  occupancy == DEPTH
almost_empty  output  1  occupancy <= empty_umbral_in
almost_full  output  1  occupancy >= full_umbral_in
err  output  1  sticky overflow/underflow flag
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
max_count  output  ADDR_WIDTH+1  peak occupancy (optional feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr = rd_ptr = count = 0.
  - data_out = 0, valid_out = 0, err = 0, max_count = 0.
  - fifo_empty = 1, almost_empty = 1, fifo_full = 0.
  - almost_full = (0 >= full_umbral_in).
  - Memory contents are not cleared.
- Reset mid-operation discards all stored words; on the first edge after release the block is empty.
- Pointers are ADDR_WIDTH bits and wrap modulo DEPTH. count is tracked separately, ADDR_WIDTH+1 bits.
- Push accepted when (!fifo_full) or (pop && fifo_full): mem[wr_ptr] <= data_in, wr_ptr++.
- Pop accepted when !fifo_empty: data_out <= mem[rd_ptr], rd_ptr++, valid_out <= 1.
  - Otherwise valid_out <= 0 and data_out holds its value.
  - Read latency: 1 cycle.
- count next value:
  - push only: +1.
  - pop only: -1.
  - both accepted: unchanged.
- Boundary cases:
  - Full with push and pop: both accepted, count stays DEPTH. The read returns the old head before the write lands.
  - Empty with push and pop: push accepted, pop rejected (underflow), count becomes 1.
  - Push while full without pop: overflow. Word dropped; err <= 1.
  - Pop while empty: underflow. valid_out <= 0; err <= 1.
- err is sticky until reset.
- fifo_empty and fifo_full are registered, derived from next count.
- almost_empty and almost_full are combinational compares of the registered count against the live umbral inputs.
  - An umbral change is reflected in the same cycle.
  - full_umbral_in = 0 forces almost_full = 1.
  - Umbral width ADDR_WIDTH caps the threshold at DEPTH-1.
- No state machine beyond the pointer/count datapath. The FSM stays upstream.

Optional Feature:
FIFO_PEAK_EN:
- Defined: max_count <= max(max_count, next count) every cycle; cleared only by reset.
- Undefined: max_count is tied to 0 and no peak register is synthesized.

Decomposition:
- Package fifo_pkg: DATA_WIDTH and ADDR_WIDTH defaults, DEPTH constant, count-width constant.
  - MF_SIZE, VC_SIZE and D_SIZE umbral-width constants, shared with the FSM and its bench.
- Sub-module fifo_mem:
  - DEPTH x DATA_WIDTH register array.
  - One synchronous write port, one registered read port.
  - Not reset.
- fifo_umbral holds pointers, count, flags, err and the peak logic.

Test Plan:
1. Reset=0 for 2 cycles, then release. Expect fifo_empty=1, almost_empty=1, count=0, err=0, valid_out=0, data_out=0.
2. full_umbral_in=3'b101, empty_umbral_in=3'b010. Push 6'h01..6'h05 on consecutive cycles.
   - almost_empty drops when count=3.
   - almost_full rises when count=5.
   - fifo_full stays 0.
3. Fill to 8 (6'h01..6'h08), then push 6'h3F alone. Expect the word dropped, count=8, err=1.
   - Then pop 8 times: data_out 01..08, valid_out=1 each cycle after the pop, fifo_empty=1 at the end.
4. On an empty FIFO, pop. Expect valid_out=0 and err=1.
   - Then push+pop together on an empty FIFO: count=1, valid_out=0.
5. Fill to 8, then push 6'h2A with pop together. Expect data_out=6'h01, count=8.
   - Drain: the last word out is 6'h2A (wrap-around verified).
6. Push 4 words, assert reset=0 mid-stream for 1 cycle. Expect count=0 and err=0 immediately (asynchronous).
   - With FIFO_PEAK_EN defined, max_count=0 after reset and 4 before it. Undefined: max_count always 0.
